// File: rtl/draw_sdram_scheduler.sv
`default_nettype none
// draw_sdram_scheduler: per-frame, index-ordered owner of the SDRAM write port; owns frame_flip.
// Optional per-grant watchdog release is built when DRAW_SCHED_WATCHDOG_EN is defined.
module draw_sdram_scheduler #(
  parameter int          N_CLIENTS = 4,
  parameter logic [15:0] WD_CYCLES = 16'd60000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     new_frame,
  input  logic [N_CLIENTS-1:0]     cl_enable,
  input  logic [N_CLIENTS-1:0]     cl_wr,
  input  logic [N_CLIENTS-1:0]     cl_done,
  input  logic [22*N_CLIENTS-1:0]  cl_addr,
  input  logic [128*N_CLIENTS-1:0] cl_data,
  input  logic [16*N_CLIENTS-1:0]  cl_be,
  output logic [N_CLIENTS-1:0]     cl_wait,
  output logic [N_CLIENTS-1:0]     cl_ac,
  input  logic                     sdram_wait_in,
  input  logic                     sdram_ac_in,
  output logic                     sdram_wr,
  output logic [21:0]              sdram_addr,
  output logic [127:0]             sdram_data,
  output logic [15:0]              sdram_be,
  output logic [N_CLIENTS-1:0]     grant,
  output logic                     frame_flip,
  output logic                     frame_ready,
  output logic                     overrun,
  output logic [N_CLIENTS-1:0]     wd_err
);

  localparam int IW = $clog2(N_CLIENTS);
  localparam int PW = $clog2(N_CLIENTS + 1);

  typedef enum logic [2:0] {
    WAIT_FRAME = 3'd0,
    SELECT     = 3'd1,
    OWN        = 3'd2,
    HANDOVER   = 3'd3,
    FRAME_DONE = 3'd4
  } state_t;

  state_t               state;
  logic [N_CLIENTS-1:0] en_q;
  logic [PW-1:0]        p;
  logic [IW-1:0]        cur;
  logic                 sel_found;
  logic [IW-1:0]        sel_idx;

`ifdef DRAW_SCHED_WATCHDOG_EN
  logic [15:0]          wd_cnt;
  logic [N_CLIENTS-1:0] wd_err_q;
  assign wd_err = wd_err_q;
`else
  logic unused_wd;
  assign wd_err    = '0;
  assign unused_wd = ^WD_CYCLES;
`endif

  // Lowest enabled index at or above the resume pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (en_q[i] && (PW'(i) >= p)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // grant is zero outside OWN, so the mux and handshakes idle safely everywhere else.
  always_comb begin
    sdram_addr = '0;
    sdram_data = '0;
    sdram_be   = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant[i]) begin
        sdram_addr = sdram_addr | cl_addr[i*22 +: 22];
        sdram_data = sdram_data | cl_data[i*128 +: 128];
        sdram_be   = sdram_be   | cl_be[i*16 +: 16];
      end
    end
  end

  assign sdram_wr = |(grant & cl_wr);
  assign cl_wait  = ~grant | (grant & {N_CLIENTS{sdram_wait_in}});
  assign cl_ac    = grant & {N_CLIENTS{sdram_ac_in}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_FRAME;
      grant       <= '0;
      frame_flip  <= 1'b0;
      frame_ready <= 1'b1;
      overrun     <= 1'b0;
      en_q        <= '0;
      p           <= '0;
      cur         <= '0;
`ifdef DRAW_SCHED_WATCHDOG_EN
      wd_cnt      <= '0;
      wd_err_q    <= '0;
`endif
    end else begin
      overrun <= 1'b0;
      case (state)
        WAIT_FRAME, FRAME_DONE: begin
          if (new_frame) begin
            frame_flip  <= ~frame_flip;
            en_q        <= cl_enable;
            frame_ready <= 1'b0;
            p           <= '0;
            state       <= SELECT;
          end
        end
        SELECT: begin
          if (new_frame) overrun <= 1'b1;
          if (sel_found) begin
            grant <= {{(N_CLIENTS-1){1'b0}}, 1'b1} << sel_idx;
            cur   <= sel_idx;
            state <= OWN;
`ifdef DRAW_SCHED_WATCHDOG_EN
            wd_cnt <= '0;
`endif
          end else begin
            frame_ready <= 1'b1;
            state       <= FRAME_DONE;
          end
        end
        OWN: begin
          if (new_frame) overrun <= 1'b1;
`ifdef DRAW_SCHED_WATCHDOG_EN
          wd_cnt <= wd_cnt + 16'd1;
          if (!cl_done[cur] && (wd_cnt == WD_CYCLES - 16'd1)) begin
            wd_err_q[cur] <= 1'b1;
            grant         <= '0;
            state         <= HANDOVER;
          end
`endif
          if (cl_done[cur]) begin
            grant <= '0;
            state <= HANDOVER;
          end
        end
        HANDOVER: begin
          if (new_frame) overrun <= 1'b1;
          p     <= PW'(cur) + PW'(1);
          state <= SELECT;
        end
        default: begin
          grant <= '0;
          state <= WAIT_FRAME;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/draw_sdram_scheduler.md
# draw_sdram_scheduler

- Per-frame scheduler and write-port arbiter for the SDRAM frame-buffer write path.
- Sits between the drawing clients and the single SDRAM write master. Clients are the score/combo drawer, note drawers and background blitter.
- Grants the port to one client at a time, in index order, each until its `done`. Owns `frame_flip` and reports frame completion and overrun.
- Gates each client with a per-client wait: clients stall while not granted.

## Interface

Parameters:
- `N_CLIENTS`, default 4: number of drawing clients. Legal range 2..8.
- `WD_CYCLES`, default 16'd60000: watchdog limit, in cycles per grant.

Ports (vectors are packed, client i at slice i):
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high.
- `new_frame` in 1: one-cycle frame-start pulse, synchronous to `clk`.
- `cl_enable` in N_CLIENTS: client participates this frame. Sampled on `new_frame`.
- `cl_wr` in N_CLIENTS: client write strobe.
- `cl_done` in N_CLIENTS: client finished. Level; cleared by the client on `new_frame`.
- `cl_addr` in 22·N: client word address.
- `cl_data` in 128·N: client write data.
- `cl_be` in 16·N: client byte enables.
- `cl_wait` out N_CLIENTS: per-client stall.
- `cl_ac` out N_CLIENTS: per-client write accept.
- `sdram_wait_in` in 1: SDRAM master cannot start a write.
- `sdram_ac_in` in 1: current write accepted.
- `sdram_wr` out 1: write strobe to the SDRAM master.
- `sdram_addr` out 22: muxed write address.
- `sdram_data` out 128: muxed write data.
- `sdram_be` out 16: muxed byte enables.
- `grant` out N_CLIENTS: one-hot or zero. Registered.
- `frame_flip` out 1: back-buffer select (0 → offset 0x100000, 1 → 0x200000).
- `frame_ready` out 1: every enabled client is done for the current frame.
- `overrun` out 1: one-cycle pulse when `new_frame` arrives before `frame_ready`.
- `wd_err` out N_CLIENTS: sticky per-client watchdog error.

## Operation

States: `WAIT_FRAME`, `SELECT`, `OWN`, `HANDOVER`, `FRAME_DONE`.

**Reset:** state `WAIT_FRAME`. `grant`=0, `frame_flip`=0, `frame_ready`=1, `overrun`=0, `wd_err`=0, `sdram_wr`=0, `cl_wait`=all 1, `cl_ac`=0.

**`WAIT_FRAME` / `FRAME_DONE`:**
- On `new_frame`: toggle `frame_flip`, latch `cl_enable` into `en_q`, clear `frame_ready`, set index pointer `p`=0, go to `SELECT`.

**`SELECT`:**
- Find the lowest index ≥ `p` with `en_q`=1.
- If one is found, set `grant` one-hot and go to `OWN`.
- If none is found, go to `FRAME_DONE` and set `frame_ready`=1.

**`OWN`** (granted client g):
- `cl_wait[g]` = `sdram_wait_in`. All other `cl_wait` = 1.
- `sdram_wr` = `cl_wr[g]`.
- `sdram_addr`/`sdram_data`/`sdram_be` = slice g. This mux is combinational on the registered `grant`.
- `cl_ac[g]` = `sdram_ac_in`. All other `cl_ac` = 0.
- When `cl_done[g]` is sampled 1, go to `HANDOVER`.

**`HANDOVER`:**
- One dead cycle: `grant`=0, `sdram_wr`=0, all `cl_wait`=1.
- Set `p`=g+1, go to `SELECT`.

**Overrun:**
- A `new_frame` in `SELECT`, `OWN` or `HANDOVER` pulses `overrun`.
- `frame_flip` and `en_q` are unchanged and scheduling continues.
- That frame completes into `FRAME_DONE` and waits for the next `new_frame`.

**Mux outputs:**
- While `grant`=0, `sdram_addr`/`sdram_data`/`sdram_be` = 0.
- `sdram_wr` is never asserted while `grant`=0.

## Timing

- `new_frame` in `WAIT_FRAME` at cycle T:
  - `frame_flip` toggles at T+1.
  - `SELECT` at T+1.
  - `grant` at T+2.
  - `cl_wait[g]` low at T+2 if `sdram_wait_in`=0.
- `cl_done[g]`=1 at cycle D:
  - `HANDOVER` at D+1, `grant`=0.
  - Next grant at D+3.
- Zero-latency forwarding: `cl_wr` → `sdram_wr` and `sdram_ac_in` → `cl_ac` in the same cycle.
- Grant never changes while `sdram_wr`=1 and `sdram_ac_in`=0.
  - Exception: a watchdog release, which drops the write.
- `reset` asserted in any state returns all outputs to reset values on the next edge. An in-flight write is abandoned.
- `new_frame` coincident with `reset`: reset wins.

## Configuration

- `DRAW_SCHED_WATCHDOG_EN` defined:
  - 16-bit counter, cleared on each grant, counting every `OWN` cycle.
  - At `WD_CYCLES` with `cl_done[g]`=0: set `wd_err[g]` (sticky until `reset`) and go to `HANDOVER`.
  - A forced release still counts toward `frame_ready`.
- Undefined: no counter, `wd_err` tied 0, and a client may hold the port indefinitely.

## Test plan

- **Basic frame.** Reset, `cl_enable`=4'b1111, pulse `new_frame`, each client performs 3 writes then `done`.
  - `frame_flip`=1 at T+1; grants 0,1,2,3 in order with one dead cycle between each.
  - 12 writes forwarded with correct per-client addr/data/be; `frame_ready`=1 at the end.
- **Stalls.** `sdram_wait_in` held high for 10 cycles mid-grant of client 2.
  - `cl_wait[2]`=1 for those cycles, `sdram_wr` follows `cl_wr[2]`.
  - No grant change and no lost write.
- **Skip.** `cl_enable`=4'b1010.
  - Only clients 1 and 3 granted; `cl_wait[0]` and `cl_wait[2]` stay 1 all frame.
- **Overrun.** Client 1 takes longer than the frame period.
  - `overrun` pulses once.
  - `frame_flip` does not toggle on the late `new_frame`; it toggles on the following one.
- **Watchdog** (with macro, `WD_CYCLES`=100). Client 0 never asserts `done`.
  - `wd_err[0]`=1 after 100 `OWN` cycles, then client 1 granted.
  - Without the macro, client 0 holds the grant for 1000+ cycles.
- **Reset mid-write.** `reset` asserted while client 2 owns the port with `sdram_wr`=1.
  - Next cycle: `grant`=0, `sdram_wr`=0, `frame_flip`=0, `frame_ready`=1, state `WAIT_FRAME`.
